// File: rtl/iter_shifter.sv
// Iterative SLL/SRL/SRA unit that moves at most STEP bit positions per cycle.
// Sits beside the ALU in EX; the pipeline stalls while busy_o is high.
module iter_shifter #(
   parameter int         XLEN    = 32,
   parameter int         STEP    = 1,
   parameter logic [3:0] ALU_SLL = 4'b0001,
   parameter logic [3:0] ALU_SRL = 4'b0101,
   parameter logic [3:0] ALU_SRA = 4'b1101,
   localparam int        SHW     = $clog2(XLEN)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [SHW-1:0]  shamt_i,
   input  logic [3:0]      type_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] c_o
);

   localparam int KW = SHW + 1;
   localparam logic [KW-1:0] STEPK = KW'(STEP);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]      state_q;
   logic [XLEN-1:0] work_q;
   logic [SHW-1:0]  rem_q;
   logic [3:0]      op_q;
   logic            sign_q;
   logic            valid_q;
   logic [XLEN-1:0] c_q;

   logic [KW-1:0]   k;
   logic            fill;
   logic [XLEN-1:0] work_nxt;
   logic [SHW-1:0]  rem_nxt;
   logic            type_ok;

   assign type_ok = (type_i == ALU_SLL) || (type_i == ALU_SRL) || (type_i == ALU_SRA);

   // One iteration: shift by min(STEP, rem); right shifts OR in a mask of fill bits.
   always_comb begin
      k        = (KW'(rem_q) >= STEPK) ? STEPK : KW'(rem_q);
      fill     = (op_q == ALU_SRA) ? sign_q : 1'b0;
      work_nxt = '0;
      if (op_q == ALU_SLL)
         work_nxt = work_q << k;
      else
         work_nxt = (work_q >> k) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> k));
      rem_nxt  = rem_q - k[SHW-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         op_q    <= '0;
         sign_q  <= 1'b0;
         valid_q <= 1'b0;
         c_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  op_q   <= type_i;
                  rem_q  <= shamt_i;
                  sign_q <= a_i[XLEN-1];
                  if (!type_ok) begin
                     work_q  <= '0;
                     state_q <= DONE;
                  end else begin
                     work_q  <= a_i;
                     state_q <= (shamt_i != '0) ? SHIFT : DONE;
                  end
               end
            end
            SHIFT: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  work_q <= work_nxt;
                  rem_q  <= rem_nxt;
                  if (rem_nxt == '0)
                     state_q <= DONE;
               end
            end
            DONE: begin
               // A flush here drops the result so c_o keeps its previous value.
               if (!flush_i) begin
                  c_q     <= work_q;
                  valid_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o  = (state_q != IDLE);
   assign valid_o = valid_q;
   assign c_o     = c_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP=1,4,32) driven in lockstep and
// compared every cycle against a transaction-level model of the shifter.
module tb_iter_shifter;

   localparam logic [3:0] T_SLL = 4'b0001;
   localparam logic [3:0] T_SRL = 4'b0101;
   localparam logic [3:0] T_SRA = 4'b1101;
   localparam logic [3:0] T_BAD = 4'b0000;
   localparam int STEPS [3] = '{1, 4, 32};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [4:0]  shamt;
   logic [3:0]  ty;
   logic        flush;

   logic        busy  [3];
   logic        valid [3];
   logic [31:0] c     [3];

   int vectors  = 0;
   int failures = 0;
   int cyc      = 0;

   logic        m_act [3];
   int          m_fin [3];
   logic [31:0] m_res [3];
   logic [31:0] m_c   [3];
   logic        m_val [3];

   always #5 clk = ~clk;

   iter_shifter #(.XLEN(32), .STEP(1)) u_s1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .shamt_i(shamt),
      .type_i(ty), .flush_i(flush), .busy_o(busy[0]), .valid_o(valid[0]), .c_o(c[0]));
   iter_shifter #(.XLEN(32), .STEP(4)) u_s4 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .shamt_i(shamt),
      .type_i(ty), .flush_i(flush), .busy_o(busy[1]), .valid_o(valid[1]), .c_o(c[1]));
   iter_shifter #(.XLEN(32), .STEP(32)) u_s32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .shamt_i(shamt),
      .type_i(ty), .flush_i(flush), .busy_o(busy[2]), .valid_o(valid[2]), .c_o(c[2]));

   function automatic logic [31:0] ref_result(logic [31:0] x, logic [4:0] s, logic [3:0] t);
      case (t)
         T_SLL:   return x << s;
         T_SRL:   return x >> s;
         T_SRA:   return 32'($signed(x) >>> s);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_cycles(logic [4:0] s, logic [3:0] t, int step);
      if (t != T_SLL && t != T_SRL && t != T_SRA) return 0;
      return (int'(s) + step - 1) / step;
   endfunction

   task automatic applyStimulus(input logic s, input logic [31:0] x, input logic [4:0] sh,
                                input logic [3:0] t, input logic f);
      start = s;
      a     = x;
      shamt = sh;
      ty    = t;
      flush = f;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 3; i++) begin
         checkValue($sformatf("busy[step%0d] cyc%0d", STEPS[i], cyc), 32'(busy[i]), 32'(m_act[i]));
         checkValue($sformatf("valid[step%0d] cyc%0d", STEPS[i], cyc), 32'(valid[i]), 32'(m_val[i]));
         checkValue($sformatf("c[step%0d] cyc%0d", STEPS[i], cyc), c[i], m_c[i]);
      end
   endtask

   // Advance one clock edge, update the model with the inputs sampled there, then check.
   task automatic tick();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_act[i] = 1'b0;
            m_val[i] = 1'b0;
            m_c[i]   = 32'h0;
         end else begin
            m_val[i] = 1'b0;
            if (m_act[i]) begin
               if (flush) begin
                  m_act[i] = 1'b0;
               end else if (cyc == m_fin[i]) begin
                  m_c[i]   = m_res[i];
                  m_val[i] = 1'b1;
                  m_act[i] = 1'b0;
               end
            end else if (start) begin
               m_act[i] = 1'b1;
               m_res[i] = ref_result(a, shamt, ty);
               m_fin[i] = cyc + ref_cycles(shamt, ty, STEPS[i]) + 1;
            end
         end
      end
      #1;
      checkOutput();
   endtask

   function automatic logic [3:0] pick_type();
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) return T_SLL;
      if (r < 6) return T_SRL;
      if (r < 9) return T_SRA;
      return T_BAD;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_act[i] = 1'b0; m_fin[i] = 0; m_res[i] = '0; m_c[i] = '0; m_val[i] = 1'b0;
      end
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] SLL 1<<31");
      applyStimulus(1'b1, 32'h0000_0001, 5'd31, T_SLL, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (8) tick();
      checkValue("t1 busy before result", 32'(busy[1]), 32'd1);
      tick();
      checkValue("t1 valid step4", 32'(valid[1]), 32'd1);
      checkValue("t1 c step4", c[1], 32'h8000_0000);
      repeat (26) tick();

      $display("[TB] SRA/SRL 0x80000000 by 4");
      applyStimulus(1'b1, 32'h8000_0000, 5'd4, T_SRA, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (5) tick();
      checkValue("t2 sra valid step1", 32'(valid[0]), 32'd1);
      checkValue("t2 sra c step1", c[0], 32'hF800_0000);
      applyStimulus(1'b1, 32'h8000_0000, 5'd4, T_SRL, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (6) tick();
      checkValue("t2 srl c step1", c[0], 32'h0800_0000);

      $display("[TB] zero shift and unsupported type");
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd0, T_SRA, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      tick();
      checkValue("t3 zero-shift valid step32", 32'(valid[2]), 32'd1);
      checkValue("t3 zero-shift c step32", c[2], 32'hDEAD_BEEF);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd9, T_BAD, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      tick();
      checkValue("t3 bad type c step1", c[0], 32'h0);

      $display("[TB] start held during busy");
      applyStimulus(1'b1, 32'h1234_5678, 5'd10, T_SRL, 1'b0);
      tick();
      applyStimulus(1'b1, 32'hCAFE_F00D, 5'd7, T_SLL, 1'b0);
      repeat (12) tick();
      checkValue("t4 first result step1", c[0], 32'h0004_8D15);
      repeat (20) tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (12) tick();

      $display("[TB] flush mid-operation");
      applyStimulus(1'b1, 32'hFFFF_0000, 5'd20, T_SRL, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b1);
      tick();
      applyStimulus(1'b1, 32'h0000_00F0, 5'd3, T_SLL, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (5) tick();
      checkValue("t5 restart c step1", c[0], 32'h0000_0780);

      $display("[TB] reset mid-shift");
      applyStimulus(1'b1, 32'hA5A5_A5A5, 5'd30, T_SRA, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      checkValue("t6 busy after reset", 32'(busy[0]), 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] random sweep");
      for (int n = 0; n < 200; n++) begin
         applyStimulus(1'b1, $urandom, 5'($urandom), pick_type(), 1'b0);
         tick();
         applyStimulus($urandom_range(0, 7) == 0, $urandom, 5'($urandom), pick_type(), 1'b0);
         for (int w = $urandom_range(1, 36); w > 0; w--) begin
            flush = ($urandom_range(0, 40) == 0);
            tick();
            start = 1'b0;
            flush = 1'b0;
         end
      end
      applyStimulus(1'b0, 32'h0, 5'd0, T_SLL, 1'b0);
      repeat (36) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

endmodule
